// File: rtl/terminal_uart_dump.sv
// terminal_uart_dump: streams a ROWSxCOLUMNS text RAM out of an 8N1 UART, row by row with CR/LF.
module terminal_uart_dump #(
  parameter int BAUD_DIVISOR = 217,
  parameter int COLUMNS      = 80,
  parameter int ROWS         = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] textAddress,
  input  logic [7:0]  textReadData,
  output logic        uartTx
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, CR, LF, FINISH} state_t;
  localparam logic [11:0] C_LAST = 12'(COLUMNS - 1);
  localparam logic [11:0] R_LAST = 12'(ROWS - 1);
  localparam logic [11:0] C_W    = 12'(COLUMNS);
  localparam logic [15:0] B_LAST = 16'(BAUD_DIVISOR - 1);
  state_t      state_q, state_d;
  logic [11:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
  logic        busy_q, busy_d, done_q, done_d, tx_q, tx_d, act_q, act_d;
  logic [8:0]  frame_q, frame_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic        frame_end, bit_end, load;
  logic [7:0]  load_byte, mapped;
  assign mapped = (textReadData == 8'h00) ? 8'h20 :
                  (textReadData < 8'h20 || textReadData > 8'h7e) ? 8'h2e : textReadData;
  assign bit_end   = act_q && baud_q == B_LAST;
  assign frame_end = bit_end && bit_q == 4'd9;
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_byte = mapped;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        row_d   = '0;
        col_d   = '0;
        busy_d  = 1'b1;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: if (frame_end) begin
        col_d     = (col_q == C_LAST) ? '0 : col_q + 12'd1;
        state_d   = (col_q == C_LAST) ? CR : FETCH;
        load      = col_q == C_LAST;
        load_byte = 8'h0d;
      end
      CR: if (frame_end) begin
        state_d   = LF;
        load      = 1'b1;
        load_byte = 8'h0a;
      end
      LF: if (frame_end) begin
        row_d   = row_q + 12'd1;
        state_d = (row_q == R_LAST) ? FINISH : FETCH;
        done_d  = row_q == R_LAST;
        busy_d  = row_q != R_LAST;
      end
      default: state_d = IDLE;
    endcase
    addr_d  = (state_d == FETCH) ? row_d * C_W + col_d : addr_q;
    tx_d    = bit_end ? frame_q[0] : tx_q;
    frame_d = bit_end ? {1'b1, frame_q[8:1]} : frame_q;
    baud_d  = act_q ? (bit_end ? '0 : baud_q + 16'd1) : baud_q;
    bit_d   = bit_end ? (frame_end ? '0 : bit_q + 4'd1) : bit_q;
    act_d   = act_q && !frame_end;
    // A load restarts the shifter; the start bit appears on the line next cycle.
    if (load) begin
      act_d   = 1'b1;
      baud_d  = '0;
      bit_d   = '0;
      frame_d = {1'b1, load_byte};
      tx_d    = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
      frame_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      frame_q <= frame_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign textAddress = addr_q;
  assign uartTx      = tx_q;
endmodule

// File: tb/tb_terminal_uart_dump.sv
// tb_terminal_uart_dump: randomized screen dumps decoded by a bench UART receiver and compared to a text model.
module tb_terminal_uart_dump;
  localparam int BA = 4, CA = 2, RA = 2;
  localparam int BB = 1, CB = 80, RB = 30;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_a = 1'b0, start_a = 1'b0, busy_a, done_a, tx_a;
  logic        reset_b = 1'b0, start_b = 1'b0, busy_b, done_b, tx_b;
  logic [11:0] addr_a, addr_b;
  logic [7:0]  rd_a, rd_b;
  logic [7:0]  mem_a [CA*RA];
  logic [7:0]  mem_b [CB*RB];
  int checks = 0, errors = 0;
  int done_cnt [2] = '{0, 0};
  int busy_at_done [2] = '{0, 0};
  int aq_a [$];
  int aq_b [$];
  terminal_uart_dump #(.BAUD_DIVISOR(BA), .COLUMNS(CA), .ROWS(RA)) dut_a (
    .clock(clk), .reset(reset_a), .start(start_a), .busy(busy_a), .done(done_a),
    .textAddress(addr_a), .textReadData(rd_a), .uartTx(tx_a));
  terminal_uart_dump #(.BAUD_DIVISOR(BB), .COLUMNS(CB), .ROWS(RB)) dut_b (
    .clock(clk), .reset(reset_b), .start(start_b), .busy(busy_b), .done(done_b),
    .textAddress(addr_b), .textReadData(rd_b), .uartTx(tx_b));
  always @(posedge clk) begin
    rd_a <= (int'(addr_a) < CA*RA) ? mem_a[int'(addr_a)] : 8'h00;
    rd_b <= (int'(addr_b) < CB*RB) ? mem_b[int'(addr_b)] : 8'h00;
  end
  always @(negedge clk) begin
    if (done_a) begin done_cnt[0]++; if (busy_a) busy_at_done[0]++; end
    if (done_b) begin done_cnt[1]++; if (busy_b) busy_at_done[1]++; end
    if (busy_a && (aq_a.size() == 0 || aq_a[$] != int'(addr_a))) aq_a.push_back(int'(addr_a));
    if (busy_b && (aq_b.size() == 0 || aq_b[$] != int'(addr_b))) aq_b.push_back(int'(addr_b));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_map(input logic [7:0] b);
    if (b == 8'h00) return 8'h20;
    if (b >= 8'h20 && b <= 8'h7e) return b;
    return 8'h2e;
  endfunction
  function automatic logic tx_of(input int s);
    return s != 0 ? tx_b : tx_a;
  endfunction
  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h1f;
      2: return 8'h20;
      3: return 8'h7e;
      4: return 8'h7f;
      5: return 8'hff;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction
  task automatic fill_a();
    for (int i = 0; i < CA*RA; i++) mem_a[i] = pick_byte();
  endtask
  task automatic pulse_start(input int s);
    @(negedge clk);
    if (s != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask
  // Receiver: waits for a start bit, then requires every bit to hold for exactly the baud period.
  task automatic rx_frame(input int s, output logic [7:0] data, output bit ok, output int gap);
    int bd;
    logic [9:0] bits;
    logic v;
    bd = (s != 0) ? BB : BA;
    ok = 1'b1;
    gap = 0;
    data = '0;
    while (tx_of(s) !== 1'b0) begin
      if (gap >= 400) begin ok = 1'b0; return; end
      @(negedge clk);
      gap++;
    end
    for (int i = 0; i < 10; i++) begin
      v = tx_of(s);
      bits[i] = v;
      for (int c = 0; c < bd; c++) begin
        if (tx_of(s) !== v) ok = 1'b0;
        @(negedge clk);
      end
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
    data = bits[8:1];
  endtask
  task automatic check_dump(input int s, input string tag);
    int cols, rows, d0, b0, base, gap, abad;
    logic [7:0] exp_q [$];
    logic [7:0] d;
    bit ok;
    int q [$];
    cols = (s != 0) ? CB : CA;
    rows = (s != 0) ? RB : RA;
    d0 = done_cnt[s];
    b0 = busy_at_done[s];
    base = (s != 0) ? aq_b.size() : aq_a.size();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++)
        if (s != 0) exp_q.push_back(ref_map(mem_b[r*cols+c]));
        else exp_q.push_back(ref_map(mem_a[r*cols+c]));
      exp_q.push_back(8'h0d);
      exp_q.push_back(8'h0a);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      rx_frame(s, d, ok, gap);
      chk($sformatf("%s frame%0d shape", tag, i), 32'(ok), 32'd1);
      if (!ok) break;
      chk($sformatf("%s frame%0d byte", tag, i), 32'(d), 32'(exp_q[i]));
      if (i > 0) chk($sformatf("%s frame%0d gap<=3", tag, i), 32'(gap <= 3), 32'd1);
    end
    repeat (3) @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt[s] - d0), 32'd1);
    chk({tag, " busy with done"}, 32'(busy_at_done[s] - b0), 32'd0);
    chk({tag, " busy after"}, 32'(s != 0 ? busy_b : busy_a), 32'd0);
    if (s != 0) q = aq_b; else q = aq_a;
    abad = 0;
    for (int j = 0; j < q.size() - base; j++) if (q[base+j] != j) abad++;
    chk({tag, " addr count"}, 32'(q.size() - base), 32'(cols*rows));
    chk({tag, " addr order"}, 32'(abad), 32'd0);
    chk({tag, " last addr"}, 32'(s != 0 ? addr_b : addr_a), 32'(cols*rows - 1));
  endtask
  initial begin
    int bad, d0, gap;
    logic [7:0] d;
    bit ok;
    reset_a = 1'b1;
    reset_b = 1'b1;
    start_a = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b0;
    chk("rst busy_a", 32'(busy_a), 32'd0);
    chk("rst done_a", 32'(done_a), 32'd0);
    chk("rst tx_a", 32'(tx_a), 32'd1);
    chk("rst addr_a", 32'(addr_a), 32'd0);
    chk("rst busy_b", 32'(busy_b), 32'd0);
    chk("rst tx_b", 32'(tx_b), 32'd1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    mem_a[0] = 8'h00; mem_a[1] = 8'h07; mem_a[2] = 8'h7f; mem_a[3] = 8'h7e;
    pulse_start(0);
    check_dump(0, "map");
    for (int k = 0; k < 4; k++) begin
      fill_a();
      pulse_start(0);
      check_dump(0, $sformatf("rand%0d", k));
    end
    fill_a();
    pulse_start(0);
    fork
      begin
        repeat (15) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
      end
    join_none
    check_dump(0, "restart");
    d0 = done_cnt[0];
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy_a || !tx_a) bad++;
    end
    chk("restart idle after", 32'(bad), 32'd0);
    chk("restart extra done", 32'(done_cnt[0] - d0), 32'd0);
    fill_a();
    pulse_start(0);
    rx_frame(0, d, ok, gap);
    chk("midrst frame0 shape", 32'(ok), 32'd1);
    chk("midrst frame0 byte", 32'(d), 32'(ref_map(mem_a[0])));
    gap = 0;
    while (tx_a !== 1'b0 && gap < 20) begin @(negedge clk); gap++; end
    chk("midrst start bit seen", 32'(tx_a), 32'd0);
    d0 = done_cnt[0];
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    chk("midrst tx", 32'(tx_a), 32'd1);
    chk("midrst busy", 32'(busy_a), 32'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_a || !tx_a) bad++;
    end
    chk("midrst quiet", 32'(bad), 32'd0);
    chk("midrst no done", 32'(done_cnt[0] - d0), 32'd0);
    pulse_start(0);
    check_dump(0, "after_rst");
    @(negedge clk);
    start_a = 1'b1;
    reset_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    reset_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_a || !tx_a) bad++;
      @(negedge clk);
    end
    chk("start+reset dropped", 32'(bad), 32'd0);
    for (int i = 0; i < CB*RB; i++) mem_b[i] = pick_byte();
    pulse_start(1);
    check_dump(1, "full");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
